sop_scan_eval: RTL

Programmable sum-of-products evaluator. It is the runtime-loadable successor to our fixed, generated minimized-logic netlists. A minimized cover is written into an internal cube table: one implicant per entry, as a care mask plus a value. Input vectors then arrive over a valid/ready stream, and the block scans the cubes one per cycle with early exit on the first hit. It returns F and the index of the implicant that covered the vector.

---
 rtl/sop_scan_eval_pkg.sv | 29 ++
 rtl/sop_scan_eval_if.sv | 51 +++++
 rtl/sop_scan_eval_cube_table.sv | 49 ++++
 rtl/sop_scan_eval.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sop_scan_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sop_pkg
// Description : Shared types and helpers for the sum-of-products scan
//               evaluator: FSM state encoding and the cube match test.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sop_pkg;

    // Widest vector the match helper accepts; callers zero-extend to this.
    localparam int c_match_w = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } sop_state_e;

    // A cube covers a vector when every literal it cares about agrees with
    // the vector. Zero-extended upper bits have mask 0, so they never veto.
    function automatic logic cube_match(input logic [c_match_w-1:0] vec,
                                        input logic [c_match_w-1:0] mask,
                                        input logic [c_match_w-1:0] val);
        return ((vec ^ val) & mask) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sop_scan_eval_if.sv
`default_nettype none
// ============================================================================
// Module      : sop_scan_eval_if
// Description : Bundle of the configuration port, the input-vector stream and
//               the result stream of the sum-of-products evaluator.
// Ports       : cfg_we/cfg_idx/cfg_mask/cfg_val  - cube table write
//               cfg_len_we/cfg_len               - active term count write
//               cfg_err                          - dropped-write pulse
//               in_valid/in_ready/in_vec         - input vector stream
//               out_valid/out_ready/out_f/out_hit_idx - result stream
//               master = driver of config/inputs, slave = evaluator
// Revision    : 1.0 - initial release
// ============================================================================
interface sop_scan_eval_if #(
    parameter int N_VARS    = 5,
    parameter int MAX_TERMS = 16
);
    localparam int c_iw = $clog2(MAX_TERMS);
    localparam int c_lw = $clog2(MAX_TERMS + 1);

    logic              cfg_we;
    logic [c_iw-1:0]   cfg_idx;
    logic [N_VARS-1:0] cfg_mask;
    logic [N_VARS-1:0] cfg_val;
    logic              cfg_len_we;
    logic [c_lw-1:0]   cfg_len;
    logic              cfg_err;

    logic              in_valid;
    logic              in_ready;
    logic [N_VARS-1:0] in_vec;

    logic              out_valid;
    logic              out_ready;
    logic              out_f;
    logic [c_iw-1:0]   out_hit_idx;

    modport master (
        output cfg_we, cfg_idx, cfg_mask, cfg_val, cfg_len_we, cfg_len,
        output in_valid, in_vec, out_ready,
        input  cfg_err, in_ready, out_valid, out_f, out_hit_idx
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_mask, cfg_val, cfg_len_we, cfg_len,
        input  in_valid, in_vec, out_ready,
        output cfg_err, in_ready, out_valid, out_f, out_hit_idx
    );

endinterface
`default_nettype wire

// File: rtl/sop_scan_eval_cube_table.sv
`default_nettype none
// ============================================================================
// Module      : sop_cube_table
// Description : Implicant storage: MAX_TERMS entries of {mask, val}, one
//               write port, one combinational read port, cleared on reset.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               i_we/i_wr_idx       - write strobe and entry index
//               i_wr_mask/i_wr_val  - cube written to the entry
//               i_rd_idx            - entry being examined by the scan
//               o_rd_mask/o_rd_val  - cube at i_rd_idx
// Revision    : 1.0 - initial release
// ============================================================================
module sop_cube_table #(
    parameter int N_VARS    = 5,
    parameter int MAX_TERMS = 16
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         i_we,
    input  wire logic [$clog2(MAX_TERMS)-1:0] i_wr_idx,
    input  wire logic [N_VARS-1:0]            i_wr_mask,
    input  wire logic [N_VARS-1:0]            i_wr_val,
    input  wire logic [$clog2(MAX_TERMS)-1:0] i_rd_idx,
    output logic      [N_VARS-1:0]            o_rd_mask,
    output logic      [N_VARS-1:0]            o_rd_val
);

    logic [N_VARS-1:0] r_mask [MAX_TERMS];
    logic [N_VARS-1:0] r_val  [MAX_TERMS];

    // A cleared entry (mask 0) is a constant-1 term, which is harmless
    // because entries beyond the active count are never examined.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_TERMS; i++) begin
                r_mask[i] <= '0;
                r_val[i]  <= '0;
            end
        end else if (i_we) begin
            r_mask[i_wr_idx] <= i_wr_mask;
            r_val[i_wr_idx]  <= i_wr_val;
        end
    end

    assign o_rd_mask = r_mask[i_rd_idx];
    assign o_rd_val  = r_val[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/sop_scan_eval.sv
`default_nettype none
// ============================================================================
// Module      : sop_scan_eval
// Description : Programmable sum-of-products evaluator. Scans the loaded
//               cube table one entry per cycle and stops at the first cube
//               covering the input vector, returning F and the hit index.
// Ports       : clk   - clock, all state changes on the rising edge
//               rst_n - synchronous active-low reset
//               bus   - sop_scan_eval_if.slave (config, input and result
//                       streams)
// Revision    : 1.0 - initial release
// ============================================================================
module sop_scan_eval
    import sop_pkg::*;
#(
    parameter int N_VARS    = 5,
    parameter int MAX_TERMS = 16
) (
    input wire logic        clk,
    input wire logic        rst_n,
    sop_scan_eval_if.slave  bus
);

    localparam int c_iw = $clog2(MAX_TERMS);
    localparam int c_lw = $clog2(MAX_TERMS + 1);

    sop_state_e        r_state;
    logic [c_iw-1:0]   r_idx;
    logic [c_lw-1:0]   r_num_terms;
    logic [N_VARS-1:0] r_vec;
    logic              r_f;
    logic [c_iw-1:0]   r_hit_idx;
    logic              r_out_valid;
    logic              r_cfg_err;

    logic              w_idle;
    logic              w_cfg_any;
    logic              w_tbl_we;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_hit;
    logic              w_last;
    logic [c_lw-1:0]   w_len_clamped;
    logic [N_VARS-1:0] w_rd_mask;
    logic [N_VARS-1:0] w_rd_val;

    assign w_idle    = (r_state == IDLE);
    assign w_cfg_any = bus.cfg_we | bus.cfg_len_we;
    assign w_tbl_we  = bus.cfg_we & w_idle;

    // Config writes win over an incoming vector in the same cycle; the
    // vector simply waits. Ready is also forced low while reset is held.
    assign w_in_ready = rst_n & w_idle & ~w_cfg_any;
    assign w_accept   = bus.in_valid & w_in_ready;

    assign w_len_clamped = (bus.cfg_len > c_lw'(MAX_TERMS)) ? c_lw'(MAX_TERMS)
                                                            : bus.cfg_len;

    sop_cube_table #(
        .N_VARS    (N_VARS),
        .MAX_TERMS (MAX_TERMS)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_tbl_we),
        .i_wr_idx  (bus.cfg_idx),
        .i_wr_mask (bus.cfg_mask),
        .i_wr_val  (bus.cfg_val),
        .i_rd_idx  (r_idx),
        .o_rd_mask (w_rd_mask),
        .o_rd_val  (w_rd_val)
    );

    assign w_hit = cube_match(c_match_w'(r_vec), c_match_w'(w_rd_mask),
                              c_match_w'(w_rd_val));

    // SCAN is only entered with num_terms >= 1, so the subtraction never
    // wraps while this term is in use.
    assign w_last = (c_lw'(r_idx) == (r_num_terms - c_lw'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_num_terms <= '0;
            r_vec       <= '0;
            r_f         <= 1'b0;
            r_hit_idx   <= '0;
            r_out_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            // One pulse per cycle in which a write arrives outside IDLE.
            r_cfg_err <= w_cfg_any & ~w_idle;

            if (bus.cfg_len_we && w_idle) begin
                r_num_terms <= w_len_clamped;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_vec <= bus.in_vec;
                        r_idx <= '0;
                        if (r_num_terms == '0) begin
                            r_state     <= DONE;
                            r_f         <= 1'b0;
                            r_hit_idx   <= '0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_hit) begin
                        r_state     <= DONE;
                        r_f         <= 1'b1;
                        r_hit_idx   <= r_idx;
                        r_out_valid <= 1'b1;
                    end else if (w_last) begin
                        r_state     <= DONE;
                        r_f         <= 1'b0;
                        r_hit_idx   <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_iw'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_f       = r_f;
    assign bus.out_hit_idx = r_hit_idx;
    assign bus.cfg_err     = r_cfg_err;

endmodule
`default_nettype wire
